// File: rtl/dma_copy.sv
// Single-channel word copy engine: CPU-programmed SRC/DST/LEN registers, then
// the block requests the bus and moves LEN words with a read/capture/write sequence.
module dma_copy #(
  parameter int               BITS = 32,
  parameter logic [BITS-1:0]  BASE = 32'hF0000200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            busReq,
  input  logic            busGnt,
  output logic [BITS-1:0] mAddr,
  output logic            mWe,
  output logic            mRe,
  output logic [BITS-1:0] mData
);

  localparam logic [BITS-1:0] ADDR_SRC  = BASE;
  localparam logic [BITS-1:0] ADDR_DST  = BASE + BITS'(4);
  localparam logic [BITS-1:0] ADDR_LEN  = BASE + BITS'(8);
  localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(12);

  typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR, FIN} stateType;

  stateType        state, nextState;
  logic [BITS-1:0] srcReg, dstReg, lenReg, holdReg;
  logic            done;
  logic            busy;
  logic            regWrEn;
  logic            startWr;

  assign busy    = (state == REQ) || (state == RD) || (state == CAP) || (state == WR);
  assign regWrEn = we && !busy;
  assign startWr = regWrEn && (memAddr == ADDR_CTRL) && dataBusIn[0];

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (startWr) nextState = REQ;
      FIN:  nextState = startWr ? REQ : IDLE;
      REQ: begin
        if (lenReg == '0)  nextState = FIN;
        else if (busGnt)   nextState = RD;
      end
      RD:  nextState = CAP;
      CAP: nextState = WR;
      // With the grant still held, skip REQ so each word costs exactly three cycles.
      WR: begin
        if (lenReg == BITS'(1)) nextState = FIN;
        else if (busGnt)        nextState = RD;
        else                    nextState = REQ;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      srcReg  <= '0;
      dstReg  <= '0;
      lenReg  <= '0;
      holdReg <= '0;
      done    <= 1'b0;
    end else begin
      state <= nextState;
      if (startWr)                 done <= 1'b0;
      else if (nextState == FIN)   done <= 1'b1;
      if (regWrEn && memAddr == ADDR_SRC) srcReg <= dataBusIn;
      if (regWrEn && memAddr == ADDR_DST) dstReg <= dataBusIn;
      if (regWrEn && memAddr == ADDR_LEN) lenReg <= dataBusIn;
      if (state == CAP) holdReg <= dataBusIn;
      if (state == WR) begin
        srcReg <= srcReg + BITS'(4);
        dstReg <= dstReg + BITS'(4);
        lenReg <= lenReg - BITS'(1);
      end
    end
  end

  always_comb begin
    busReq = busy;
    mRe    = (state == RD);
    mWe    = (state == WR);
    mAddr  = '0;
    mData  = '0;
    if (state == RD) mAddr = srcReg;
    if (state == WR) begin
      mAddr = dstReg;
      mData = holdReg;
    end
  end

  // Register reads are suppressed while the bus belongs to us.
  always_comb begin
    dataBusOut = '0;
    if (re && !busGnt) begin
      case (memAddr)
        ADDR_SRC:  dataBusOut = srcReg;
        ADDR_DST:  dataBusOut = dstReg;
        ADDR_LEN:  dataBusOut = lenReg;
        ADDR_CTRL: dataBusOut = {{(BITS-3){1'b0}}, done, busy, 1'b0};
        default:   dataBusOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: directed transfers push expected bus strobes,
// a negedge monitor pops and compares every mRe/mWe cycle.
module tb_dma_copy;

  localparam logic [31:0] BASE   = 32'hF0000200;
  localparam logic [31:0] A_SRC  = BASE;
  localparam logic [31:0] A_DST  = BASE + 32'd4;
  localparam logic [31:0] A_LEN  = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset, we, re, busGnt;
  logic [31:0] memAddr, cpuData, memData, dataBusIn, dataBusOut, mAddr, mData;
  logic        busReq, mWe, mRe;

  typedef struct packed {
    logic        isWr;
    logic [31:0] addr;
    logic [31:0] data;
  } busTxn;

  busTxn expQ[$];
  int    nChecks = 0;
  int    nErrors = 0;

  assign dataBusIn = cpuData | memData;

  dma_copy #(.BITS(32), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
    .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .busReq(busReq),
    .busGnt(busGnt), .mAddr(mAddr), .mWe(mWe), .mRe(mRe), .mData(mData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  // One-cycle read latency memory.
  initial memData = '0;
  always @(posedge clk) memData <= mRe ? memWord(mAddr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    busTxn t;
    if (mRe || mWe) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected strobe: got mRe=%0b mWe=%0b addr %h, expected none", mRe, mWe, mAddr);
      end else begin
        t = expQ.pop_front();
        check("strobe mWe", {31'b0, mWe}, {31'b0, t.isWr});
        check("strobe mRe", {31'b0, mRe}, {31'b0, !t.isWr});
        check("strobe addr", mAddr, t.addr);
        check("strobe data", mData, t.data);
      end
    end
  end

  task automatic pushRd(input logic [31:0] a);
    busTxn t;
    t.isWr = 1'b0; t.addr = a; t.data = '0;
    expQ.push_back(t);
  endtask

  task automatic pushWr(input logic [31:0] a, input logic [31:0] d);
    busTxn t;
    t.isWr = 1'b1; t.addr = a; t.data = d;
    expQ.push_back(t);
  endtask

  task automatic cpuWrite(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; memAddr = a; cpuData = d;
    @(posedge clk); #1;
    we = 1'b0; memAddr = '0; cpuData = '0;
  endtask

  task automatic checkReg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    re = 1'b1; memAddr = a;
    #2 d = dataBusOut;
    re = 1'b0; memAddr = '0;
    check(name, d, exp);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busReq && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'b0, busReq}, 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1; we = 1'b0; re = 1'b0; busGnt = 1'b0; memAddr = '0; cpuData = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkReg("reset SRC", A_SRC, 32'h0);
    checkReg("reset DST", A_DST, 32'h0);
    checkReg("reset LEN", A_LEN, 32'h0);
    checkReg("reset CTRL", A_CTRL, 32'h0);
    check("reset busReq", {31'b0, busReq}, 32'h0);
    checkReg("unmapped read", BASE + 32'd16, 32'h0);

    // Zero-length transfer.
    cpuWrite(A_LEN, 32'h0);
    cpuWrite(A_CTRL, 32'h1);
    check("len0 busReq in REQ", {31'b0, busReq}, 32'h1);
    @(posedge clk); #1;
    checkReg("len0 CTRL done", A_CTRL, 32'h4);
    busGnt = 1'b1;
    checkReg("grant masks read", A_CTRL, 32'h0);
    busGnt = 1'b0;

    // Three words with the grant held.
    cpuWrite(A_SRC, 32'h100);
    cpuWrite(A_DST, 32'h200);
    cpuWrite(A_LEN, 32'h3);
    pushRd(32'h100); pushWr(32'h200, 32'h5A5A0100);
    pushRd(32'h104); pushWr(32'h204, 32'h5A5A0104);
    pushRd(32'h108); pushWr(32'h208, 32'h5A5A0108);
    cpuWrite(A_CTRL, 32'h1);
    busGnt = 1'b1;
    n = 0;
    while (busReq && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("3-word cycle count", n, 32'd10);
    busGnt = 1'b0;
    checkReg("3-word CTRL", A_CTRL, 32'h4);
    checkReg("3-word LEN", A_LEN, 32'h0);
    checkReg("3-word SRC", A_SRC, 32'h10C);
    checkReg("3-word DST", A_DST, 32'h20C);
    check("3-word queue drained", expQ.size(), 32'h0);

    // Grant dropped after the first read.
    cpuWrite(A_SRC, 32'h300);
    cpuWrite(A_DST, 32'h400);
    cpuWrite(A_LEN, 32'h2);
    pushRd(32'h300); pushWr(32'h400, 32'h5A5A0300);
    pushRd(32'h304); pushWr(32'h404, 32'h5A5A0304);
    cpuWrite(A_CTRL, 32'h1);
    busGnt = 1'b1;
    n = 0;
    while (!mRe && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drop: saw first read", {31'b0, mRe}, 32'h1);
    busGnt = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drop: busReq held", {31'b0, busReq}, 32'h1);
    check("drop: one word done", expQ.size(), 32'h2);
    checkReg("drop: CTRL busy", A_CTRL, 32'h2);
    busGnt = 1'b1;
    waitIdle("drop: finished");
    busGnt = 1'b0;
    checkReg("drop: SRC", A_SRC, 32'h308);
    checkReg("drop: LEN", A_LEN, 32'h0);
    check("drop: queue drained", expQ.size(), 32'h0);

    // Writes while busy are ignored.
    cpuWrite(A_SRC, 32'h500);
    cpuWrite(A_DST, 32'h600);
    cpuWrite(A_LEN, 32'h2);
    cpuWrite(A_CTRL, 32'h1);
    cpuWrite(A_LEN, 32'h7);
    cpuWrite(A_CTRL, 32'h1);
    checkReg("busy: LEN kept", A_LEN, 32'h2);
    checkReg("busy: CTRL", A_CTRL, 32'h2);
    pushRd(32'h500); pushWr(32'h600, 32'h5A5A0500);
    pushRd(32'h504); pushWr(32'h604, 32'h5A5A0504);
    busGnt = 1'b1;
    waitIdle("busy: finished");
    repeat (5) @(posedge clk);
    #1 busGnt = 1'b0;
    check("busy: no restart", {31'b0, busReq}, 32'h0);
    checkReg("busy: CTRL done", A_CTRL, 32'h4);
    checkReg("busy: SRC", A_SRC, 32'h508);
    check("busy: queue drained", expQ.size(), 32'h0);

    // Source address wrap.
    cpuWrite(A_SRC, 32'hFFFFFFFC);
    cpuWrite(A_DST, 32'h700);
    cpuWrite(A_LEN, 32'h2);
    pushRd(32'hFFFFFFFC); pushWr(32'h700, 32'hA5A5FFFC);
    pushRd(32'h00000000); pushWr(32'h704, 32'h5A5A0000);
    cpuWrite(A_CTRL, 32'h1);
    busGnt = 1'b1;
    waitIdle("wrap: finished");
    busGnt = 1'b0;
    checkReg("wrap: SRC", A_SRC, 32'h4);
    check("wrap: queue drained", expQ.size(), 32'h0);

    // Reset during the first write.
    cpuWrite(A_SRC, 32'h800);
    cpuWrite(A_DST, 32'h900);
    cpuWrite(A_LEN, 32'h3);
    pushRd(32'h800);
    cpuWrite(A_CTRL, 32'h1);
    busGnt = 1'b1;
    n = 0;
    while (!mWe && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstWR: in write", {31'b0, mWe}, 32'h1);
    check("rstWR: write addr", mAddr, 32'h900);
    check("rstWR: write data", mData, 32'h5A5A0800);
    #1 reset = 1'b1;
    #1;
    check("rstWR: mWe dropped", {31'b0, mWe}, 32'h0);
    check("rstWR: mAddr zero", mAddr, 32'h0);
    check("rstWR: mData zero", mData, 32'h0);
    check("rstWR: busReq zero", {31'b0, busReq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    busGnt = 1'b0;
    checkReg("rstWR: SRC", A_SRC, 32'h0);
    checkReg("rstWR: DST", A_DST, 32'h0);
    checkReg("rstWR: LEN", A_LEN, 32'h0);
    checkReg("rstWR: CTRL", A_CTRL, 32'h0);
    check("rstWR: queue drained", expQ.size(), 32'h0);
    cpuWrite(A_CTRL, 32'h1);
    check("post-reset start", {31'b0, busReq}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    checkReg("post-reset done", A_CTRL, 32'h4);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
